child: RTL
==========

Name: child

Overview:
- Counterpart of the parent FSM on the wakeup/food/book handshake.
- It sleeps for a hunger interval, then pulses wakeup to request service.
- It consumes the one-cycle food and book pulses the parent returns: eats, then reads, then sleeps again.
- It retries unanswered calls, raises a crying alarm when retries run out, and counts completed meals. It sits beside parent in the hw_week7 top.

Parameters:
- HUNGER_CYCLES, 8: cycles spent in SLEEP before calling.
- FOOD_TIMEOUT, 4: cycles to wait for food after a call.
- MAX_RETRY, 2: extra calls allowed before crying.
- EAT_CYCLES, 3: cycles spent eating.
- BOOK_TIMEOUT, 4: cycles to wait for book after eating.
- READ_CYCLES, 5: cycles spent reading.

Ports:
- clk  input  1  system clock, rising edge.
- resetb  input  1  synchronous, active-high reset. The port keeps the codebase name; it is asserted high.
- food  input  1  food pulse from parent.
- book  input  1  book pulse from parent.
- wakeup  output  1  one-cycle request pulse to parent.
- eating  output  1  high while in EAT.
- reading  output  1  high while in READ.
- crying  output  1  high while in CRY.
- spurious  output  1  sticky; set by food or book arriving in a state that does not expect it.
- meal_count  output  8  completed meal+book cycles, saturating at 255.

Behaviour:
- One clock; synchronous active-high reset; all state and outputs registered.
- Moore outputs decoded from the registered state.
- Reset state and values: SLEEP; all counters 0; wakeup=eating=reading=crying=spurious=0; meal_count=0.
- Reset asserted mid-operation returns to SLEEP on the next edge and clears everything, including spurious and meal_count.
- Timer: a single down-counter is loaded on every state entry with (duration-1) and decrements each cycle. "Expired" means the counter is 0.
- SLEEP:
  - Lasts exactly HUNGER_CYCLES cycles, then goes to CALL.
  - Retry count is cleared on entry.
- CALL:
  - wakeup=1 for exactly one cycle, then WAIT_FOOD.
  - First wakeup is high in cycle HUNGER_CYCLES after reset release (cycles counted from 0).
- WAIT_FOOD:
  - food=1 goes to EAT.
  - If book=1 in the same cycle, set book_pending.
  - On expiry without food: if retry<MAX_RETRY, increment retry and go to CALL; otherwise go to CRY.
- EAT:
  - Lasts EAT_CYCLES cycles.
  - book=1 at any time in EAT sets book_pending.
  - At expiry: if book_pending (or book=1 that cycle), go to READ; otherwise go to WAIT_BOOK.
- WAIT_BOOK:
  - book=1 goes to READ.
  - Expiry without book goes to CRY.
- READ:
  - Lasts READ_CYCLES cycles.
  - On exit: meal_count increments (held at 255 once reached), book_pending clears, next state SLEEP.
- CRY:
  - crying=1; no timeout.
  - food=1 goes to EAT with retry cleared. Otherwise CRY persists.
- Spurious events set spurious, which stays set until reset:
  - food outside WAIT_FOOD/CRY;
  - book outside WAIT_FOOD/EAT/WAIT_BOOK.
- A spurious event never changes state.
- Simultaneous events:
  - food+book in WAIT_FOOD is legal (EAT with book_pending).
  - food+book in CRY: EAT with book_pending set.
- Parameters are at least 1. Duration counters are ceil(log2(max param)) bits wide; retry is ceil(log2(MAX_RETRY+1)) bits wide.

Decomposition:
- Package child_pkg:
  - state encoding localparams S_SLEEP, S_CALL, S_WAIT_FOOD, S_EAT, S_WAIT_BOOK, S_READ, S_CRY (3 bits);
  - default duration constants.
- Sub-module child_timer:
  - load/decrement down-counter with a WIDTH parameter;
  - inputs: load, load_value;
  - output: expired.
- The top FSM in child instantiates one child_timer.

Test Plan:
1. Reset, then idle with food=book=0 -> wakeup pulses in cycle 8, then in cycle 13, then in cycle 18 (CALL+4 timeout each). crying rises in cycle 23 and stays high. meal_count=0.
2. Nominal handshake: food pulse 2 cycles after wakeup, book 1 cycle later -> eating high 3 cycles, then reading high 5 cycles, then SLEEP. meal_count=1. Next wakeup arrives 8 cycles after READ exits.
3. food and book in the same cycle in WAIT_FOOD -> EAT 3 cycles, then READ directly (no WAIT_BOOK). meal_count=1.
4. food delivered but book never sent -> after EAT, WAIT_BOOK 4 cycles, then crying=1. A later food pulse goes to EAT, then WAIT_BOOK again.
5. food pulse during SLEEP -> spurious=1, state unchanged, wakeup still in cycle 8. spurious stays high until resetb=1, which clears it.
6. resetb=1 asserted during READ -> next cycle reading=0, state SLEEP, meal_count=0. Run 256 nominal meals -> meal_count holds at 255.

Source files
------------

// File: rtl/child_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | child_pkg: state encoding and default durations for the child FSM.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package child_pkg;

    localparam logic [2:0] S_SLEEP     = 3'd0;
    localparam logic [2:0] S_CALL      = 3'd1;
    localparam logic [2:0] S_WAIT_FOOD = 3'd2;
    localparam logic [2:0] S_EAT       = 3'd3;
    localparam logic [2:0] S_WAIT_BOOK = 3'd4;
    localparam logic [2:0] S_READ      = 3'd5;
    localparam logic [2:0] S_CRY       = 3'd6;

    localparam int C_HUNGER_CYCLES = 8;
    localparam int C_FOOD_TIMEOUT  = 4;
    localparam int C_MAX_RETRY     = 2;
    localparam int C_EAT_CYCLES    = 3;
    localparam int C_BOOK_TIMEOUT  = 4;
    localparam int C_READ_CYCLES   = 5;

    localparam logic [7:0] C_MEAL_MAX = 8'hFF;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/child_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | child_timer: loadable down-counter that flags expiry when it reaches 0.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module child_timer #(
    parameter int               WIDTH       = 3,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_count;

    // Holds at zero once expired so a state without a timeout never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= RESET_VALUE;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_expired = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/child.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | child: sleeps, calls the parent for food, eats, reads, retries and cries.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module child
    import child_pkg::*;
#(
    parameter int HUNGER_CYCLES = C_HUNGER_CYCLES,
    parameter int FOOD_TIMEOUT  = C_FOOD_TIMEOUT,
    parameter int MAX_RETRY     = C_MAX_RETRY,
    parameter int EAT_CYCLES    = C_EAT_CYCLES,
    parameter int BOOK_TIMEOUT  = C_BOOK_TIMEOUT,
    parameter int READ_CYCLES   = C_READ_CYCLES
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       food,
    input  logic       book,
    output logic       wakeup,
    output logic       eating,
    output logic       reading,
    output logic       crying,
    output logic       spurious,
    output logic [7:0] meal_count
);

    localparam int MAX_DUR = max_of(max_of(max_of(HUNGER_CYCLES, FOOD_TIMEOUT),
                                           max_of(EAT_CYCLES, BOOK_TIMEOUT)),
                                    READ_CYCLES);
    localparam int TW      = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;
    localparam int RW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [TW-1:0] C_LD_SLEEP = TW'(HUNGER_CYCLES - 1);
    localparam logic [TW-1:0] C_LD_WFOOD = TW'(FOOD_TIMEOUT - 1);
    localparam logic [TW-1:0] C_LD_EAT   = TW'(EAT_CYCLES - 1);
    localparam logic [TW-1:0] C_LD_WBOOK = TW'(BOOK_TIMEOUT - 1);
    localparam logic [TW-1:0] C_LD_READ  = TW'(READ_CYCLES - 1);
    localparam logic [RW-1:0] C_RETRY_LIMIT = RW'(MAX_RETRY);

    logic [2:0]    r_state;
    logic [RW-1:0] r_retry;
    logic          r_book_pending;
    logic          r_spurious;
    logic [7:0]    r_meal_count;
    logic          r_wakeup;
    logic          r_eating;
    logic          r_reading;
    logic          r_crying;

    logic [2:0]    w_next_state;
    logic          w_expired;
    logic          w_load;
    logic [TW-1:0] w_load_value;
    logic          w_set_pending;
    logic          w_retry_inc;
    logic          w_retry_clr;
    logic          w_spurious_evt;
    logic          w_read_done;

    child_timer #(
        .WIDTH       (TW),
        .RESET_VALUE (C_LD_SLEEP)
    ) u_timer (
        .clk          (clk),
        .rst          (resetb),
        .i_load       (w_load),
        .i_load_value (w_load_value),
        .o_expired    (w_expired)
    );

    always_comb begin
        w_next_state  = r_state;
        w_set_pending = 1'b0;
        w_retry_inc   = 1'b0;
        case (r_state)
            S_SLEEP: begin
                if (w_expired) w_next_state = S_CALL;
            end
            S_CALL: begin
                w_next_state = S_WAIT_FOOD;
            end
            S_WAIT_FOOD: begin
                if (food) begin
                    w_next_state  = S_EAT;
                    w_set_pending = book;
                end else if (w_expired) begin
                    if (r_retry < C_RETRY_LIMIT) begin
                        w_next_state = S_CALL;
                        w_retry_inc  = 1'b1;
                    end else begin
                        w_next_state = S_CRY;
                    end
                end
            end
            S_EAT: begin
                w_set_pending = book;
                if (w_expired) begin
                    w_next_state = (r_book_pending || book) ? S_READ : S_WAIT_BOOK;
                end
            end
            S_WAIT_BOOK: begin
                if (book)           w_next_state = S_READ;
                else if (w_expired) w_next_state = S_CRY;
            end
            S_READ: begin
                if (w_expired) w_next_state = S_SLEEP;
            end
            S_CRY: begin
                if (food) begin
                    w_next_state  = S_EAT;
                    w_set_pending = book;
                end
            end
            default: begin
                w_next_state = S_SLEEP;
            end
        endcase
    end

    // Every state change reloads the shared timer with the new state's duration.
    always_comb begin
        w_load_value = '0;
        case (w_next_state)
            S_SLEEP:     w_load_value = C_LD_SLEEP;
            S_WAIT_FOOD: w_load_value = C_LD_WFOOD;
            S_EAT:       w_load_value = C_LD_EAT;
            S_WAIT_BOOK: w_load_value = C_LD_WBOOK;
            S_READ:      w_load_value = C_LD_READ;
            default:     w_load_value = '0;
        endcase
    end

    assign w_load      = (w_next_state != r_state);
    assign w_read_done = (r_state == S_READ) && w_expired;
    assign w_retry_clr = (w_next_state == S_SLEEP) ||
                         ((r_state == S_CRY) && (w_next_state == S_EAT));

    always_comb begin
        w_spurious_evt = 1'b0;
        if (food && (r_state != S_WAIT_FOOD) && (r_state != S_CRY)) begin
            w_spurious_evt = 1'b1;
        end
        if (book && (r_state != S_WAIT_FOOD) && (r_state != S_EAT) &&
            (r_state != S_WAIT_BOOK)) begin
            w_spurious_evt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (resetb) begin
            r_state        <= S_SLEEP;
            r_retry        <= '0;
            r_book_pending <= 1'b0;
            r_spurious     <= 1'b0;
            r_meal_count   <= '0;
            r_wakeup       <= 1'b0;
            r_eating       <= 1'b0;
            r_reading      <= 1'b0;
            r_crying       <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if (w_retry_clr) begin
                r_retry <= '0;
            end else if (w_retry_inc) begin
                r_retry <= r_retry + RW'(1);
            end

            if (w_read_done) begin
                r_book_pending <= 1'b0;
            end else if (w_set_pending) begin
                r_book_pending <= 1'b1;
            end

            if (w_spurious_evt) begin
                r_spurious <= 1'b1;
            end

            if (w_read_done && (r_meal_count != C_MEAL_MAX)) begin
                r_meal_count <= r_meal_count + 8'd1;
            end

            // Outputs are registered from the next state so they align with r_state.
            r_wakeup  <= (w_next_state == S_CALL);
            r_eating  <= (w_next_state == S_EAT);
            r_reading <= (w_next_state == S_READ);
            r_crying  <= (w_next_state == S_CRY);
        end
    end

    assign wakeup     = r_wakeup;
    assign eating     = r_eating;
    assign reading    = r_reading;
    assign crying     = r_crying;
    assign spurious   = r_spurious;
    assign meal_count = r_meal_count;

endmodule
`default_nettype wire
